// File: rtl/ysyx_25020037_icache.sv
// Direct-mapped read-only instruction cache between the IFU and its AXI read master.
// A lookup either answers with a one-cycle hit pulse or raises a block-aligned line-fill
// request. The IFU returns the fill as one block. Also provides fence.i invalidation
// and hit/miss counters.
module ysyx_25020037_icache #(
    parameter int BLOCK_SIZE = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [31:0]             icache_addr,
    input  logic                    icache_req,
    output logic [31:0]             icache_data,
    output logic                    icache_hit,
    output logic                    icache_ready,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic [BLOCK_SIZE*8-1:0] mem_data,
    input  logic                    mem_ready,
    input  logic                    mem_err,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);

    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WORDS  = BLOCK_SIZE / 4;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LINE_W = BLOCK_SIZE * 8;

    typedef enum logic {
        S_IDLE,
        S_MISS
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_line [NUM_LINES];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WORD_W-1:0] w_word;
    logic              w_lookup_hit;
    logic [31:0]       w_hit_word;
    logic [31:0]       w_fill_word;
    logic              w_fill_done;
    logic              w_unused_bits;

    logic [IDX_W-1:0]  r_miss_idx;
    logic [TAG_W-1:0]  r_miss_tag;
    logic [WORD_W-1:0] r_miss_word;
    logic              r_flush_pend;
    logic              r_hit;
    logic [31:0]       r_data_out;
    logic              r_mem_req;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_hit_cnt;
    logic [31:0]       r_miss_cnt;

    assign w_idx         = icache_addr[OFF_W +: IDX_W];
    assign w_tag         = icache_addr[31 -: TAG_W];
    assign w_unused_bits = ^icache_addr[1:0];
    assign w_lookup_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill_done   = (r_state == S_MISS) && mem_ready;

    generate
        if (WORDS > 1) begin : g_word_sel
            assign w_word = icache_addr[OFF_W-1:2];
        end else begin : g_word_zero
            assign w_word = '0;
        end
    endgenerate

    assign icache_data = r_data_out;
    assign icache_hit  = r_hit;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign hit_cnt     = r_hit_cnt;
    assign miss_cnt    = r_miss_cnt;

    // Pick the addressed word out of the stored line and out of the incoming fill block
    always_comb begin
        w_hit_word  = 32'h0;
        w_fill_word = 32'h0;
        for (int k = 0; k < WORDS; k++) begin
            if (WORD_W'(k) == w_word) begin
                w_hit_word = r_line[w_idx][32*k +: 32];
            end
            if (WORD_W'(k) == r_miss_word) begin
                w_fill_word = mem_data[32*k +: 32];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and ready: a missing lookup leaves IDLE, a returned fill comes back
    always_comb begin
        w_next       = r_state;
        icache_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                icache_ready = 1'b1;
                if (icache_req && !w_lookup_hit) begin
                    w_next = S_MISS;
                end
            end
            S_MISS: begin
                if (mem_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Control datapath: hit pulse, fill request, valid bits, pending flush, counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= '0;
            r_hit        <= 1'b0;
            r_data_out   <= 32'h0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_hit_cnt    <= 32'h0;
            r_miss_cnt   <= 32'h0;
            r_miss_idx   <= '0;
            r_miss_tag   <= '0;
            r_miss_word  <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (r_state == S_IDLE) begin
                if (icache_req) begin
                    if (w_lookup_hit) begin
                        r_hit      <= 1'b1;
                        r_data_out <= w_hit_word;
                        r_hit_cnt  <= r_hit_cnt + 32'd1;
                    end else begin
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= {icache_addr[31:OFF_W], {OFF_W{1'b0}}};
                        r_miss_cnt  <= r_miss_cnt + 32'd1;
                        r_miss_idx  <= w_idx;
                        r_miss_tag  <= w_tag;
                        r_miss_word <= w_word;
                    end
                end
                if (flush) begin
                    r_valid <= '0;
                end
            end else begin
                if (flush) begin
                    r_flush_pend <= 1'b1;
                end
                if (mem_ready) begin
                    r_mem_req    <= 1'b0;
                    r_flush_pend <= 1'b0;
                    r_data_out   <= mem_err ? 32'h0 : w_fill_word;
                    if (r_flush_pend || flush) begin
                        r_valid <= '0;
                    end else if (!mem_err) begin
                        r_valid[r_miss_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    // Tag and line storage, written only by an error-free fill
    always_ff @(posedge clk) begin
        if (w_fill_done && !mem_err) begin
            r_tag[r_miss_idx]  <= r_miss_tag;
            r_line[r_miss_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_icache.sv
// Bench for the instruction cache: one instance with 4-byte lines and one with 16-byte
// lines share a clock. A lookup table drives the 4-byte instance; hand sequences cover
// flush, the wide-line word select and reset during a fill.
module tb_ysyx_25020037_icache;

    typedef struct {
        logic [31:0] addr;
        logic        expHit;
        logic [31:0] fill;
        logic        err;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        logic        hit;
        logic [31:0] memAddr;
        logic [31:0] data;
    } expect_t;

    logic         clk;
    logic         rst_n;
    logic         sel;
    logic         req;
    logic         flush;
    logic [31:0]  addr;
    logic         memReady;
    logic         memErr;
    logic [127:0] memData;

    logic        aReq, aFlush, aMemReady;
    logic [31:0] aData, aMemAddr, aHitCnt, aMissCnt;
    logic        aHit, aReady, aMemReq;
    logic        bReq, bFlush, bMemReady;
    logic [31:0] bData, bMemAddr, bHitCnt, bMissCnt;
    logic        bHit, bReady, bMemReq;

    logic [31:0] oData, oMemAddr, oHitCnt, oMissCnt;
    logic        oHit, oReady, oMemReq;

    int      nAsserts;
    int      nFails;
    int      expHits [2];
    int      expMisses [2];
    expect_t sb [$];
    vec_t    vecs [10];

    assign aReq      = req & ~sel;
    assign bReq      = req & sel;
    assign aFlush    = flush & ~sel;
    assign bFlush    = flush & sel;
    assign aMemReady = memReady & ~sel;
    assign bMemReady = memReady & sel;

    assign oData    = sel ? bData    : aData;
    assign oHit     = sel ? bHit     : aHit;
    assign oReady   = sel ? bReady   : aReady;
    assign oMemReq  = sel ? bMemReq  : aMemReq;
    assign oMemAddr = sel ? bMemAddr : aMemAddr;
    assign oHitCnt  = sel ? bHitCnt  : aHitCnt;
    assign oMissCnt = sel ? bMissCnt : aMissCnt;

    ysyx_25020037_icache #(.BLOCK_SIZE(4), .NUM_LINES(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(aFlush),
        .icache_addr(addr), .icache_req(aReq),
        .icache_data(aData), .icache_hit(aHit), .icache_ready(aReady),
        .mem_req(aMemReq), .mem_addr(aMemAddr), .mem_data(memData[31:0]),
        .mem_ready(aMemReady), .mem_err(memErr),
        .hit_cnt(aHitCnt), .miss_cnt(aMissCnt)
    );

    ysyx_25020037_icache #(.BLOCK_SIZE(16), .NUM_LINES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .flush(bFlush),
        .icache_addr(addr), .icache_req(bReq),
        .icache_data(bData), .icache_hit(bHit), .icache_ready(bReady),
        .mem_req(bMemReq), .mem_addr(bMemAddr), .mem_data(memData),
        .mem_ready(bMemReady), .mem_err(memErr),
        .hit_cnt(bHitCnt), .miss_cnt(bMissCnt)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation and keep the tallies
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nAsserts++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One lookup on the selected instance; a miss is serviced with the given fill block
    task automatic applyStimulus(input logic [31:0] a, input logic fl, input logic expHit,
                                 input logic [127:0] fill, input logic err,
                                 input logic [31:0] expData, input logic flushMid);
        expect_t e;
        int      s;
        s = sel ? 1 : 0;
        e.hit     = expHit;
        e.memAddr = a & (sel ? 32'hFFFF_FFF0 : 32'hFFFF_FFFC);
        e.data    = expData;
        sb.push_back(e);
        if (expHit) expHits[s]++;
        else expMisses[s]++;

        @(negedge clk);
        addr  = a;
        req   = 1'b1;
        flush = fl;
        @(posedge clk);
        #1;
        req   = 1'b0;
        flush = 1'b0;
        e = sb.pop_front();
        checkOutput("hit_pulse", {31'h0, oHit}, {31'h0, e.hit});
        if (e.hit) begin
            checkOutput("hit_data", oData, e.data);
            checkOutput("hit_no_memreq", {31'h0, oMemReq}, 32'h0);
            @(posedge clk);
            #1;
            checkOutput("hit_one_cycle", {31'h0, oHit}, 32'h0);
        end else begin
            checkOutput("miss_memreq", {31'h0, oMemReq}, 32'h1);
            checkOutput("miss_memaddr", oMemAddr, e.memAddr);
            checkOutput("miss_not_ready", {31'h0, oReady}, 32'h0);
            @(negedge clk);
            req   = 1'b1;
            flush = flushMid;
            @(posedge clk);
            #1;
            req   = 1'b0;
            flush = 1'b0;
            checkOutput("miss_hold_memreq", {31'h0, oMemReq}, 32'h1);
            checkOutput("miss_no_hit", {31'h0, oHit}, 32'h0);
            @(negedge clk);
            memReady = 1'b1;
            memData  = fill;
            memErr   = err;
            @(posedge clk);
            #1;
            memReady = 1'b0;
            memErr   = 1'b0;
            checkOutput("fill_data", oData, e.data);
            checkOutput("fill_memreq_low", {31'h0, oMemReq}, 32'h0);
            checkOutput("fill_no_hit", {31'h0, oHit}, 32'h0);
            checkOutput("fill_ready", {31'h0, oReady}, 32'h1);
        end
        checkOutput("hit_cnt", oHitCnt, 32'(expHits[s]));
        checkOutput("miss_cnt", oMissCnt, 32'(expMisses[s]));
    endtask

    initial begin
        vecs[0] = '{32'h3000_0000, 1'b0, 32'h0000_0413, 1'b0, 32'h0000_0413};
        vecs[1] = '{32'h3000_0000, 1'b1, 32'h0,         1'b0, 32'h0000_0413};
        vecs[2] = '{32'h3000_0040, 1'b0, 32'h1111_1111, 1'b0, 32'h1111_1111};
        vecs[3] = '{32'h3000_0000, 1'b0, 32'h0000_0413, 1'b0, 32'h0000_0413};
        vecs[4] = '{32'h3000_0004, 1'b0, 32'h2222_2222, 1'b1, 32'h0000_0000};
        vecs[5] = '{32'h3000_0004, 1'b0, 32'h3333_3333, 1'b0, 32'h3333_3333};
        vecs[6] = '{32'h3000_0004, 1'b1, 32'h0,         1'b0, 32'h3333_3333};
        vecs[7] = '{32'h3000_0000, 1'b1, 32'h0,         1'b0, 32'h0000_0413};
        vecs[8] = '{32'h8000_003C, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[9] = '{32'h8000_003C, 1'b1, 32'h0,         1'b0, 32'hDEAD_BEEF};

        nAsserts  = 0;
        nFails    = 0;
        expHits   = '{0, 0};
        expMisses = '{0, 0};
        sel       = 1'b0;
        req       = 1'b0;
        flush     = 1'b0;
        addr      = 32'h0;
        memReady  = 1'b0;
        memErr    = 1'b0;
        memData   = '0;
        rst_n     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_data", aData, 32'h0);
        checkOutput("rst_hit", {31'h0, aHit}, 32'h0);
        checkOutput("rst_ready", {31'h0, aReady}, 32'h1);
        checkOutput("rst_memreq", {31'h0, aMemReq}, 32'h0);
        checkOutput("rst_memaddr", aMemAddr, 32'h0);
        checkOutput("rst_hitcnt", aHitCnt, 32'h0);
        checkOutput("rst_misscnt", aMissCnt, 32'h0);
        checkOutput("rst16_memreq", {31'h0, bMemReq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].addr, 1'b0, vecs[i].expHit, {96'h0, vecs[i].fill},
                          vecs[i].err, vecs[i].expData, 1'b0);
        end

        // Flush with a request in the same cycle still hits, then the line is gone
        applyStimulus(32'h3000_0004, 1'b1, 1'b1, 128'h0, 1'b0, 32'h3333_3333, 1'b0);
        applyStimulus(32'h3000_0004, 1'b0, 1'b0, {96'h0, 32'h4444_4444}, 1'b0,
                      32'h4444_4444, 1'b0);
        applyStimulus(32'h3000_0000, 1'b0, 1'b0, {96'h0, 32'h0000_0413}, 1'b0,
                      32'h0000_0413, 1'b0);

        // Flush during a fill: data still returned, nothing left valid
        applyStimulus(32'h3000_0008, 1'b0, 1'b0, {96'h0, 32'h5555_5555}, 1'b0,
                      32'h5555_5555, 1'b1);
        applyStimulus(32'h3000_0008, 1'b0, 1'b0, {96'h0, 32'h5555_5555}, 1'b0,
                      32'h5555_5555, 1'b0);
        applyStimulus(32'h3000_0000, 1'b0, 1'b0, {96'h0, 32'h0000_0413}, 1'b0,
                      32'h0000_0413, 1'b0);
        applyStimulus(32'h3000_0008, 1'b0, 1'b1, 128'h0, 1'b0, 32'h5555_5555, 1'b0);

        // 16-byte lines: word selection within the block
        sel = 1'b1;
        applyStimulus(32'hA000_0000, 1'b0, 1'b0,
                      {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000},
                      1'b0, 32'hC0DE_0000, 1'b0);
        applyStimulus(32'hA000_0008, 1'b0, 1'b1, 128'h0, 1'b0, 32'hC0DE_0002, 1'b0);
        applyStimulus(32'hA000_000C, 1'b0, 1'b1, 128'h0, 1'b0, 32'hC0DE_0003, 1'b0);
        applyStimulus(32'hA000_0014, 1'b0, 1'b0,
                      {32'h0000_0004, 32'h0000_0005, 32'h0000_0006, 32'h0000_0007},
                      1'b0, 32'h0000_0006, 1'b0);
        sel = 1'b0;

        // Reset in the middle of a fill drops it and clears every line
        applyStimulus(32'h3000_0010, 1'b0, 1'b0, {96'h0, 32'h6666_6666}, 1'b0,
                      32'h6666_6666, 1'b0);
        applyStimulus(32'h3000_0010, 1'b0, 1'b1, 128'h0, 1'b0, 32'h6666_6666, 1'b0);
        @(negedge clk);
        addr = 32'h3000_0014;
        req  = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        checkOutput("pre_rst_memreq", {31'h0, aMemReq}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_memreq", {31'h0, aMemReq}, 32'h0);
        checkOutput("midrst_ready", {31'h0, aReady}, 32'h1);
        checkOutput("midrst_data", aData, 32'h0);
        checkOutput("midrst_misscnt", aMissCnt, 32'h0);
        expHits   = '{0, 0};
        expMisses = '{0, 0};
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h3000_0010, 1'b0, 1'b0, {96'h0, 32'h7777_7777}, 1'b0,
                      32'h7777_7777, 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
